// File: rtl/immediate_encoder.sv
// ============================================================================
// Module   : immediate_encoder
// Function : Scatters a 32-bit immediate into the U/J/I/B/S fields of an RV32I
//            template, flags out-of-range immediates, and streams the result
//            through a two-stage valid/ready pipeline tagged with a word address.
// Options  : IMM_ENCODER_ERRCNT_EN adds a saturating err_count output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module immediate_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_template,
  input  logic [31:0]       in_imm,
  input  logic [2:0]        in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic              out_error,
  output logic [ADDR_W-1:0] out_addr
`ifdef IMM_ENCODER_ERRCNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  localparam logic [31:0]       c_NOP       = 32'h0000_0013;
  localparam logic [2:0]        c_SEL_U     = 3'd0;
  localparam logic [2:0]        c_SEL_J     = 3'd1;
  localparam logic [2:0]        c_SEL_I     = 3'd2;
  localparam logic [2:0]        c_SEL_B     = 3'd3;
  localparam logic [2:0]        c_SEL_S     = 3'd4;
  localparam logic [ADDR_W-1:0] c_BASE_ADDR = ADDR_W'(BASE_ADDR);

  logic              r_s1Valid;
  logic [31:0]       r_s1Template;
  logic [31:0]       r_s1Imm;
  logic [2:0]        r_s1Sel;
  logic              r_s2Valid;
  logic [31:0]       r_outInstr;
  logic              r_outError;
  logic [ADDR_W-1:0] r_outAddr;

  logic              w_inFire;
  logic              w_s2Load;
  logic              w_outFire;
  logic [31:0]       w_encInstr;
  logic              w_encError;

  assign in_ready  = !r_s1Valid || !r_s2Valid || out_ready;
  assign w_inFire  = in_valid && in_ready;
  assign w_s2Load  = r_s1Valid && (!r_s2Valid || out_ready);
  assign w_outFire = r_s2Valid && out_ready;

  assign out_valid = r_s2Valid;
  assign out_instr = r_outInstr;
  assign out_error = r_outError;
  assign out_addr  = r_outAddr;

  always_comb begin
    w_encInstr = r_s1Template;
    w_encError = 1'b0;
    case (r_s1Sel)
      c_SEL_U: begin
        w_encInstr[31:12] = r_s1Imm[31:12];
        w_encError        = (r_s1Imm[11:0] != 12'd0);
      end
      c_SEL_J: begin
        w_encInstr[31]    = r_s1Imm[20];
        w_encInstr[30:21] = r_s1Imm[10:1];
        w_encInstr[20]    = r_s1Imm[11];
        w_encInstr[19:12] = r_s1Imm[19:12];
        w_encError        = r_s1Imm[0] || (r_s1Imm[31:20] != {12{r_s1Imm[20]}});
      end
      c_SEL_I: begin
        w_encInstr[31:20] = r_s1Imm[11:0];
        w_encError        = (r_s1Imm[31:12] != {20{r_s1Imm[11]}});
      end
      c_SEL_B: begin
        w_encInstr[31]    = r_s1Imm[12];
        w_encInstr[30:25] = r_s1Imm[10:5];
        w_encInstr[11:8]  = r_s1Imm[4:1];
        w_encInstr[7]     = r_s1Imm[11];
        w_encError        = r_s1Imm[0] || (r_s1Imm[31:13] != {19{r_s1Imm[12]}});
      end
      c_SEL_S: begin
        w_encInstr[31:25] = r_s1Imm[11:5];
        w_encInstr[11:7]  = r_s1Imm[4:0];
        w_encError        = (r_s1Imm[31:12] != {20{r_s1Imm[11]}});
      end
      default: w_encError = 1'b1;
    endcase
    if (w_encError) begin
      w_encInstr = c_NOP;
    end
  end

  // out_addr doubles as the running counter, so a word loaded on the same
  // edge as a handshake naturally picks up the incremented address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1Valid    <= 1'b0;
      r_s1Template <= 32'd0;
      r_s1Imm      <= 32'd0;
      r_s1Sel      <= 3'd0;
      r_s2Valid    <= 1'b0;
      r_outInstr   <= 32'd0;
      r_outError   <= 1'b0;
      r_outAddr    <= c_BASE_ADDR;
    end else begin
      r_s1Valid <= w_inFire || (r_s1Valid && !w_s2Load);
      if (w_inFire) begin
        r_s1Template <= in_template;
        r_s1Imm      <= in_imm;
        r_s1Sel      <= in_sel;
      end
      r_s2Valid <= w_s2Load || (r_s2Valid && !out_ready);
      if (w_s2Load) begin
        r_outInstr <= w_encInstr;
        r_outError <= w_encError;
      end
      if (w_outFire) begin
        r_outAddr <= r_outAddr + 1'b1;
      end
    end
  end

`ifdef IMM_ENCODER_ERRCNT_EN
  logic [15:0] r_errCount;

  assign err_count = r_errCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_errCount <= 16'd0;
    end else if (w_outFire && r_outError && (r_errCount != 16'hFFFF)) begin
      r_errCount <= r_errCount + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_immediate_encoder.sv
// Self-checking bench for immediate_encoder: directed encodings, error cases,
// backpressure, reset mid-flight and a randomized stream against a reference model.
`default_nettype none

module tb_immediate_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_template;
  logic [31:0] in_imm;
  logic [2:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_error;
  logic [9:0]  out_addr;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_instr2;
  logic        out_error2;
  logic [1:0]  out_addr2;

`ifdef IMM_ENCODER_ERRCNT_EN
  logic [15:0] err_count;
  logic [15:0] err_count2;
`endif

  always #5 clk = ~clk;

  immediate_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_template(in_template), .in_imm(in_imm), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_error(out_error), .out_addr(out_addr)
`ifdef IMM_ENCODER_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  // Narrow-address copy sharing the same stimulus, used to observe wrap-around.
  immediate_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dutWrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_template(in_template), .in_imm(in_imm), .in_sel(in_sel),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_error(out_error2), .out_addr(out_addr2)
`ifdef IMM_ENCODER_ERRCNT_EN
    , .err_count(err_count2)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          cycleNo = 0;
  int          expAddr = 0;
  int          expErrCnt = 0;
  bit          latChk = 1'b0;
  bit          accepted = 1'b0;
  logic [32:0] reqExp;
  logic [32:0] expQ[$];
  int          accQ[$];
  bit          holdPend = 1'b0;
  logic [31:0] holdInstr;
  logic        holdErr;
  logic [9:0]  holdAddr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {error, instr} from the encoding rules using plain arithmetic.
  function automatic logic [32:0] model(input logic [31:0] t, input logic [31:0] imm,
                                        input int sel);
    longint si;
    logic   err;
    logic [31:0] r;
    si = longint'($signed(imm));
    r  = t;
    case (sel)
      0: begin
        err = (imm % 32'd4096) != 0;
        r   = (t & 32'h0000_0FFF) | (imm & 32'hFFFF_F000);
      end
      1: begin
        err = (imm % 32'd2 != 0) || si < -(64'sd1 << 20) || si >= (64'sd1 << 20);
        r   = (t & 32'h0000_0FFF) | (((imm >> 20) & 32'h1) << 31)
            | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
            | (imm & 32'h000F_F000);
      end
      2: begin
        err = si < -2048 || si > 2047;
        r   = (t & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
      end
      3: begin
        err = (imm % 32'd2 != 0) || si < -4096 || si > 4095;
        r   = (t & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
            | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
            | (((imm >> 11) & 32'h1) << 7);
      end
      4: begin
        err = si < -2048 || si > 2047;
        r   = (t & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      end
      default: err = 1'b1;
    endcase
    if (err) r = 32'h0000_0013;
    return {err, r};
  endfunction

  task automatic cycle();
    logic [32:0] e;
    int a;
    @(negedge clk);
    accepted = 1'b0;
`ifdef IMM_ENCODER_ERRCNT_EN
    chk("err_count", 64'(err_count), 64'(expErrCnt));
`endif
    if (holdPend && out_valid) begin
      chk("hold_instr", 64'(out_instr), 64'(holdInstr));
      chk("hold_error", 64'(out_error), 64'(holdErr));
      chk("hold_addr", 64'(out_addr), 64'(holdAddr));
    end
    holdPend = 1'b0;
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        chk("unexpected_word", 64'(out_instr), 64'hDEAD);
      end else begin
        e = expQ.pop_front();
        a = accQ.pop_front();
        chk("instr", 64'(out_instr), 64'(e[31:0]));
        chk("error", 64'(out_error), 64'(e[32]));
        chk("addr", 64'(out_addr), 64'(expAddr % 1024));
        chk("wrap_addr", 64'(out_addr2), 64'(expAddr % 4));
        chk("wrap_instr", 64'(out_instr2), 64'(e[31:0]));
        if (latChk) chk("latency", 64'(cycleNo - a), 64'd2);
        if (e[32] && expErrCnt < 65535) expErrCnt++;
      end
      expAddr++;
    end else if (out_valid) begin
      holdPend  = 1'b1;
      holdInstr = out_instr;
      holdErr   = out_error;
      holdAddr  = out_addr;
    end
    if (in_valid && in_ready) begin
      expQ.push_back(reqExp);
      accQ.push_back(cycleNo);
      accepted = 1'b1;
    end
    cycleNo++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] t, input logic [31:0] imm, input logic [2:0] sel,
                      input logic [32:0] exp);
    int n;
    in_template = t;
    in_imm      = imm;
    in_sel      = sel;
    reqExp      = exp;
    in_valid    = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 50);
    if (!accepted) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((expQ.size() != 0 || out_valid) && n < 100) begin
      cycle();
      n++;
    end
    chk("drain_done", 64'(expQ.size()), 64'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expQ.delete();
    accQ.delete();
    expAddr   = 0;
    expErrCnt = 0;
    holdPend  = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int k;
    logic [31:0] t, imm;
    logic [2:0]  sel;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_template = '0; in_imm = '0; in_sel = '0; reqExp = '0;
    @(posedge clk);
    #1;
    doReset();
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_error", 64'(out_error), 64'd0);

    // Directed back-to-back encodings with known results.
    latChk = 1'b1;
    send(32'h0000_00B7, 32'd0,  3'd0, {1'b0, 32'h0000_00B7});
    send(32'h0000_00EF, 32'd64, 3'd1, {1'b0, 32'h0400_00EF});
    send(32'h0000_8103, 32'd64, 3'd2, {1'b0, 32'h0400_8103});
    send(32'h0020_8063, 32'd64, 3'd3, {1'b0, 32'h0420_8063});
    send(32'h0020_8023, 32'd64, 3'd4, {1'b0, 32'h0420_8023});
    send(32'h0000_0037, 32'h1234_5000, 3'd0, {1'b0, 32'h1234_5037});
    drain();

    // Error cases: three bad words and two good ones after a fresh reset.
    doReset();
    send(32'h0000_8103, 32'd2048, 3'd2, {1'b1, 32'h0000_0013});
    send(32'h0020_8063, 32'd3,    3'd3, {1'b1, 32'h0000_0013});
    send(32'h0000_8103, 32'd0,    3'd5, {1'b1, 32'h0000_0013});
    send(32'h0000_00EF, 32'hFFFF_FFFE, 3'd1, {1'b0, 32'hFFFF_F0EF});
    send(32'h0000_8103, 32'hFFFF_F800, 3'd2, {1'b0, 32'h8000_8103});
    drain();
`ifdef IMM_ENCODER_ERRCNT_EN
    chk("err_count_total", 64'(err_count), 64'd3);
`endif

    // Backpressure: two accepts fill the pipe, then in_ready must drop.
    latChk = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || accepted) begin
        in_template = 32'h0000_0013 + (32'(k) << 7);
        in_imm      = 32'(k * 4);
        in_sel      = 3'd2;
        reqExp      = model(in_template, in_imm, 2);
      end
      cycle();
      if (accepted) k++;
    end
    chk("bp_accepts", 64'(k), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    drain();

    // Randomized stream with random backpressure.
    for (int i = 0; i < 300; i++) begin
      if (!in_valid || accepted) begin
        in_valid = ($urandom_range(0, 3) != 0);
        t   = $urandom;
        sel = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0: imm = $urandom;
          1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
          2: imm = $urandom & 32'hFFFF_F000;
          default: imm = (32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000) & ~32'h1;
        endcase
        in_template = t; in_imm = imm; in_sel = sel;
        reqExp = model(t, imm, int'(sel));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0;
    drain();

    // Reset while both stages hold data, then check clean restart latency.
    out_ready = 1'b0;
    send(32'h0000_0013, 32'd1, 3'd2, model(32'h0000_0013, 32'd1, 2));
    send(32'h0000_0013, 32'd2, 3'd2, model(32'h0000_0013, 32'd2, 2));
    cycle();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    doReset();
    out_ready = 1'b1;
    latChk = 1'b1;
    send(32'h0000_0093, 32'd7, 3'd2, {1'b0, 32'h0070_0093});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
